// File: rtl/core.sv
// Pipeline bundle types shared between execute, memory and assembly stages,
// together with the memory-stage state encoding and reset values.
package core;

  typedef struct packed {
    logic [31:0] de_inst;
    logic [31:0] pc;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] ex_result;
    logic [31:0] ex_addr;
    logic        valid;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] de_inst;
    logic [31:0] pc;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] ex_result;
    logic [31:0] ex_addr;
    logic [31:0] mem_result;
    logic        fault;
    logic        valid;
  } mem_asm_t;

  localparam ex_mem_t  ex_mem_rst  = '0;
  localparam mem_asm_t mem_asm_rst = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // The outgoing valid follows the source bundle's valid, which is always set
  // at the points where a bundle is handed downstream.
  function automatic mem_asm_t make_mem_asm(input ex_mem_t e,
                                            input logic [31:0] mem_result,
                                            input logic fault);
    mem_asm_t a;
    a.de_inst    = e.de_inst;
    a.pc         = e.pc;
    a.rs1_value  = e.rs1_value;
    a.rs2_value  = e.rs2_value;
    a.ex_result  = e.ex_result;
    a.ex_addr    = e.ex_addr;
    a.mem_result = mem_result;
    a.fault      = fault;
    a.valid      = e.valid;
    return a;
  endfunction

endpackage

// File: rtl/rv32i.sv
// RV32I opcode and funct3 constants used by the memory stage,
// plus small field-extraction helpers for instruction words.
package rv32i;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [6:0] opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [2:0] funct3(input logic [31:0] inst);
    return inst[14:12];
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment: turns funct3, byte address and register data into the
// word address, byte-enable mask and lane-shifted write data.
module mem_store_align
  import rv32i::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] rs2_value_i,
  output logic [31:0] word_addr_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o
);

  logic [1:0] off;

  assign off         = ex_addr_i[1:0];
  assign word_addr_o = {ex_addr_i[31:2], 2'b00};

  // Shifts are evaluated at 4 bits so lanes pushed past byte 3 simply vanish.
  always_comb begin
    wmask_o = 4'b1111;
    case (funct3_i)
      F3_B:    wmask_o = 4'b0001 << off;
      F3_H:    wmask_o = 4'b0011 << off;
      default: wmask_o = 4'b1111;
    endcase
  end

  assign wdata_o = rs2_value_i << {off, 3'b000};

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards non-memory instructions in one cycle and runs
// one load/store at a time over a request/response data-memory port with a
// response timeout. Define MEM_STAGE_MISALIGN_CHECK_EN to fault misaligned
// half/word accesses instead of issuing them.
module mem_stage
  import core::*;
  import rv32i::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        next_rdy,
  input  ex_mem_t     ex_mem,
  output mem_asm_t    mem_asm,
  output logic        rdy,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  mem_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  ex_mem_t     cap_q, cap_d;
  logic [31:0] res_q, res_d;
  logic        fault_q, fault_d;
  mem_asm_t    mem_asm_q, mem_asm_d;

  logic        in_is_mem;
  logic        cap_is_load;
  logic        cap_is_store;
  logic [31:0] align_addr;
  logic [3:0]  align_wmask;
  logic [31:0] align_wdata;

  assign in_is_mem    = (opcode(ex_mem.de_inst) == OPC_LOAD) ||
                        (opcode(ex_mem.de_inst) == OPC_STORE);
  assign cap_is_load  = (opcode(cap_q.de_inst) == OPC_LOAD);
  assign cap_is_store = (opcode(cap_q.de_inst) == OPC_STORE);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic       in_misaligned;
  logic [2:0] in_f3;

  assign in_f3 = funct3(ex_mem.de_inst);

  always_comb begin
    in_misaligned = 1'b0;
    if ((in_f3 == F3_H || in_f3 == F3_HU) && ex_mem.ex_addr[0])
      in_misaligned = 1'b1;
    else if (in_f3 == F3_W && ex_mem.ex_addr[1:0] != 2'b00)
      in_misaligned = 1'b1;
  end
`endif

  mem_store_align u_align (
    .funct3_i    (funct3(cap_q.de_inst)),
    .ex_addr_i   (cap_q.ex_addr),
    .rs2_value_i (cap_q.rs2_value),
    .word_addr_o (align_addr),
    .wmask_o     (align_wmask),
    .wdata_o     (align_wdata)
  );

  assign rdy            = en && next_rdy && (state_q == IDLE);
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_addr      = align_addr;
  assign dmem_we        = cap_is_store;
  assign dmem_wmask     = cap_is_store ? align_wmask : 4'b0000;
  assign dmem_wdata     = align_wdata;
  assign mem_asm        = mem_asm_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    res_d     = res_q;
    fault_d   = fault_q;
    mem_asm_d = mem_asm_q;

    // A free downstream slot with nothing handed over drains the output.
    if (next_rdy)
      mem_asm_d.valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdy && ex_mem.valid) begin
          if (in_is_mem) begin
            cap_d   = ex_mem;
            res_d   = '0;
            fault_d = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            if (in_misaligned) begin
              fault_d = 1'b1;
              state_d = DONE;
            end else begin
              state_d = REQ;
            end
`else
            state_d = REQ;
`endif
          end else begin
            mem_asm_d = make_mem_asm(ex_mem, 32'd0, 1'b0);
          end
        end
      end

      REQ: begin
        if (dmem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end

      WAIT: begin
        if (dmem_resp_valid) begin
          res_d   = cap_is_load ? dmem_rdata : 32'd0;
          fault_d = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
            res_d   = '0;
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (next_rdy) begin
          mem_asm_d = make_mem_asm(cap_q, res_q, fault_q);
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_q     <= ex_mem_rst;
      res_q     <= '0;
      fault_q   <= 1'b0;
      mem_asm_q <= mem_asm_rst;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      res_q     <= res_d;
      fault_q   <= fault_d;
      mem_asm_q <= mem_asm_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model and a
// per-cycle compare process; honours MEM_STAGE_MISALIGN_CHECK_EN when defined.
module tb_mem_stage;
  import core::*;

  localparam int TO = 4;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  localparam logic [6:0]  LD_OP = 7'h03;
  localparam logic [6:0]  ST_OP = 7'h23;
  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h00002083;
  localparam logic [31:0] LH    = 32'h00001083;
  localparam logic [31:0] LBU   = 32'h00004083;
  localparam logic [31:0] SB    = 32'h00000023;
  localparam logic [31:0] SH    = 32'h00001023;
  localparam logic [31:0] SW    = 32'h00002023;

  logic        clk = 1'b0;
  logic        rst, en, next_rdy;
  ex_mem_t     ex_mem;
  mem_asm_t    mem_asm;
  logic        rdy, dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_resp_valid;
  logic [3:0]  dmem_wmask;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h0000_0100;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .next_rdy        (next_rdy),
    .ex_mem          (ex_mem),
    .mem_asm         (mem_asm),
    .rdy             (rdy),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_we         (dmem_we),
    .dmem_wmask      (dmem_wmask),
    .dmem_wdata      (dmem_wdata),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic bit is_ld(input logic [31:0] inst);
    return inst[6:0] == LD_OP;
  endfunction

  function automatic bit is_st(input logic [31:0] inst);
    return inst[6:0] == ST_OP;
  endfunction

  function automatic logic [3:0] mdl_mask(input logic [31:0] inst, input logic [31:0] addr);
    int off;
    int m;
    off = int'(addr[1:0]);
    if (!is_st(inst)) return 4'b0000;
    case (inst[14:12])
      3'd0:    m = 1 << off;
      3'd1:    m = 3 << off;
      default: m = 15;
    endcase
    m = m & 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [31:0] rs2, input logic [31:0] addr);
    logic [63:0] w;
    w = {32'd0, rs2} << (8 * int'(addr[1:0]));
    return w[31:0];
  endfunction

  function automatic bit mdl_misaligned(input logic [31:0] inst, input logic [31:0] addr);
    logic [2:0] f3;
    f3 = inst[14:12];
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) return 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic mem_asm_t mdl_out(input ex_mem_t e, input logic [31:0] res, input logic f);
    mem_asm_t a;
    a.de_inst = e.de_inst;   a.pc = e.pc;               a.rs1_value = e.rs1_value;
    a.rs2_value = e.rs2_value; a.ex_result = e.ex_result; a.ex_addr = e.ex_addr;
    a.mem_result = res;      a.fault = f;               a.valid = 1'b1;
    return a;
  endfunction

  // phase: 0 idle, 1 request outstanding, 2 awaiting response, 3 result ready
  int          m_phase = 0;
  int          m_waited = 0;
  ex_mem_t     m_cap;
  logic [31:0] m_res;
  logic        m_fault;
  mem_asm_t    m_asm;
  bit          m_live = 1'b0;

  always @(posedge clk) begin : model
    int          ph_n;
    int          w_n;
    ex_mem_t     cap_n;
    logic [31:0] res_n;
    logic        f_n;
    mem_asm_t    asm_n;
    bit          handed;
    if (rst) begin
      m_phase <= 0; m_waited <= 0; m_cap <= '0; m_res <= '0; m_fault <= 1'b0;
      m_asm <= '0; m_live <= 1'b1;
    end else begin
      ph_n = m_phase; w_n = m_waited; cap_n = m_cap; res_n = m_res; f_n = m_fault;
      asm_n = m_asm; handed = 1'b0;
      if (m_phase == 0 && en && next_rdy && ex_mem.valid) begin
        if (is_ld(ex_mem.de_inst) || is_st(ex_mem.de_inst)) begin
          cap_n = ex_mem; res_n = '0; f_n = 1'b0;
          if (MISALIGN_EN && mdl_misaligned(ex_mem.de_inst, ex_mem.ex_addr)) begin
            f_n = 1'b1; ph_n = 3;
          end else ph_n = 1;
        end else begin
          asm_n = mdl_out(ex_mem, 32'd0, 1'b0); handed = 1'b1;
        end
      end else if (m_phase == 1 && dmem_req_ready) begin
        ph_n = 2; w_n = 0;
      end else if (m_phase == 2) begin
        w_n = m_waited + 1;
        if (dmem_resp_valid) begin
          res_n = is_ld(m_cap.de_inst) ? dmem_rdata : 32'd0; f_n = 1'b0; ph_n = 3;
        end else if (w_n >= TO) begin
          res_n = '0; f_n = 1'b1; ph_n = 3;
        end
      end else if (m_phase == 3 && next_rdy) begin
        asm_n = mdl_out(m_cap, m_res, m_fault); handed = 1'b1; ph_n = 0;
      end
      if (next_rdy && !handed) asm_n.valid = 1'b0;
      m_phase <= ph_n; m_waited <= w_n; m_cap <= cap_n; m_res <= res_n;
      m_fault <= f_n; m_asm <= asm_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    if (m_live) begin
      chk("rdy", 32'(rdy), 32'(en && next_rdy && (m_phase == 0)));
      chk("req_valid", 32'(dmem_req_valid), 32'(m_phase == 1));
      if (m_phase == 1) begin
        chk("dmem_addr", dmem_addr, {m_cap.ex_addr[31:2], 2'b00});
        chk("dmem_we", 32'(dmem_we), 32'(is_st(m_cap.de_inst)));
        chk("dmem_wmask", 32'(dmem_wmask), 32'(mdl_mask(m_cap.de_inst, m_cap.ex_addr)));
        if (is_st(m_cap.de_inst))
          chk("dmem_wdata", dmem_wdata, mdl_wdata(m_cap.rs2_value, m_cap.ex_addr));
      end
      checks++;
      if (mem_asm !== m_asm) begin
        errors++;
        $display("FAIL mem_asm: got %h expected %h", mem_asm, m_asm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2);
    ex_mem.de_inst   = inst;
    ex_mem.pc        = pc_ctr;
    ex_mem.rs1_value = 32'h1111_0000 ^ pc_ctr;
    ex_mem.rs2_value = rs2;
    ex_mem.ex_result = addr;
    ex_mem.ex_addr   = addr;
    ex_mem.valid     = 1'b1;
    pc_ctr           = pc_ctr + 32'd4;
  endtask

  // Generic access: request accepted after rdly cycles, response after rspdly WAIT cycles.
  task automatic run_mem(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int rdly, input int rspdly);
    set_in(inst, addr, rs2);
    dmem_req_ready = 1'b0;
    cyc();
    ex_mem.valid = 1'b0;
    repeat (rdly) cyc();
    dmem_req_ready = 1'b1;
    cyc();
    dmem_req_ready = 1'b0;
    repeat (rspdly) cyc();
    dmem_resp_valid = 1'b1;
    dmem_rdata = rdata;
    cyc();
    dmem_resp_valid = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic lw_timeout(input bit resp_on_last);
    set_in(LW, 32'h0000_3000, 32'd0);
    dmem_req_ready = 1'b1;
    cyc();                         // REQ
    ex_mem.valid = 1'b0;
    cyc();                         // WAIT 1
    dmem_req_ready = 1'b0;
    cyc(); cyc(); cyc();           // WAIT 4
    if (resp_on_last) begin
      dmem_resp_valid = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
    end
    cyc();                         // DONE
    dmem_resp_valid = 1'b0;
    chk("to_done_valid", 32'(mem_asm.valid), 32'd0);
    cyc();
    chk("to_valid", 32'(mem_asm.valid), 32'd1);
    chk("to_fault", 32'(mem_asm.fault), resp_on_last ? 32'd0 : 32'd1);
    chk("to_result", mem_asm.mem_result, resp_on_last ? 32'hCAFE_F00D : 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; en = 1'b1; next_rdy = 1'b1; ex_mem = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
    cyc(); cyc();
    chk("rst_valid", 32'(mem_asm.valid), 32'd0);
    chk("rst_fault", 32'(mem_asm.fault), 32'd0);
    chk("rst_req", 32'(dmem_req_valid), 32'd0);
    rst = 1'b0;

    // Non-memory instruction: one-cycle pass-through.
    set_in(ADDI, 32'h0000_0055, 32'd7);
    cyc();
    ex_mem.valid = 1'b0;
    chk("addi_valid", 32'(mem_asm.valid), 32'd1);
    chk("addi_result", mem_asm.mem_result, 32'd0);
    chk("addi_req", 32'(dmem_req_valid), 32'd0);
    cyc();
    chk("addi_drain", 32'(mem_asm.valid), 32'd0);

    // Stage disabled: nothing accepted.
    en = 1'b0;
    set_in(ADDI, 32'h0000_0077, 32'd1);
    #1;
    chk("en0_rdy", 32'(rdy), 32'd0);
    cyc();
    chk("en0_valid", 32'(mem_asm.valid), 32'd0);
    ex_mem.valid = 1'b0;
    en = 1'b1;

    // lw 0x1004 at minimum latency.
    set_in(LW, 32'h0000_1004, 32'd0);
    dmem_req_ready = 1'b1;
    cyc();                                  // T+1
    ex_mem.valid = 1'b0;
    chk("lw_req", 32'(dmem_req_valid), 32'd1);
    chk("lw_addr", dmem_addr, 32'h0000_1004);
    chk("lw_we", 32'(dmem_we), 32'd0);
    chk("lw_wmask", 32'(dmem_wmask), 32'd0);
    cyc();                                  // T+2
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    cyc();                                  // T+3
    dmem_resp_valid = 1'b0;
    chk("lw_t3_valid", 32'(mem_asm.valid), 32'd0);
    cyc();                                  // T+4
    chk("lw_valid", 32'(mem_asm.valid), 32'd1);
    chk("lw_result", mem_asm.mem_result, 32'hDEAD_BEEF);
    chk("lw_fault", 32'(mem_asm.fault), 32'd0);

    // sb 0x2003: top byte lane.
    set_in(SB, 32'h0000_2003, 32'h0000_00A5);
    dmem_req_ready = 1'b1;
    cyc();
    ex_mem.valid = 1'b0;
    chk("sb_wmask", 32'(dmem_wmask), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA500_0000);
    chk("sb_we", 32'(dmem_we), 32'd1);
    chk("sb_addr", dmem_addr, 32'h0000_2000);
    cyc();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h1234_5678;
    cyc();
    dmem_resp_valid = 1'b0;
    cyc();
    chk("sb_valid", 32'(mem_asm.valid), 32'd1);
    chk("sb_result", mem_asm.mem_result, 32'd0);

    // Timeout, then response on the final WAIT cycle.
    lw_timeout(1'b0);
    lw_timeout(1'b1);

    // Downstream stall while result is ready.
    set_in(LW, 32'h0000_1008, 32'd0);
    dmem_req_ready = 1'b1;
    cyc();                                  // REQ
    ex_mem.valid = 1'b0;
    next_rdy = 1'b0;
    cyc();                                  // WAIT
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    cyc();                                  // DONE 1
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_rdy", 32'(rdy), 32'd0);
      chk("hold_valid", 32'(mem_asm.valid), 32'd0);
      if (i < 2) cyc();
    end
    set_in(ADDI, 32'h0000_0099, 32'd3);
    next_rdy = 1'b1;
    #1;
    chk("release_rdy", 32'(rdy), 32'd0);
    cyc();
    chk("release_valid", 32'(mem_asm.valid), 32'd1);
    chk("release_result", mem_asm.mem_result, 32'h0BAD_F00D);
    chk("release_addr", mem_asm.ex_addr, 32'h0000_1008);
    chk("after_rdy", 32'(rdy), 32'd1);
    cyc();
    ex_mem.valid = 1'b0;
    chk("after_addi", mem_asm.ex_addr, 32'h0000_0099);

    // Reset in WAIT, then a stray response.
    set_in(LW, 32'h0000_4000, 32'd0);
    dmem_req_ready = 1'b1;
    cyc();
    ex_mem.valid = 1'b0;
    cyc();
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h0000_0099;
    cyc();
    dmem_resp_valid = 1'b0;
    chk("rstw_rdy", 32'(rdy), 32'd1);
    cyc(); cyc();
    chk("rstw_valid", 32'(mem_asm.valid), 32'd0);

    // Misaligned lw 0x1002.
    set_in(LW, 32'h0000_1002, 32'd0);
    dmem_req_ready = 1'b1;
    cyc();
    ex_mem.valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    chk("mis_req", 32'(dmem_req_valid), 32'd0);
    dmem_req_ready = 1'b0;
    cyc();
    chk("mis_valid", 32'(mem_asm.valid), 32'd1);
    chk("mis_fault", 32'(mem_asm.fault), 32'd1);
    chk("mis_result", mem_asm.mem_result, 32'd0);
`else
    chk("mis_req", 32'(dmem_req_valid), 32'd1);
    chk("mis_addr", dmem_addr, 32'h0000_1000);
    cyc();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h5566_7788;
    cyc();
    dmem_resp_valid = 1'b0;
    cyc();
    chk("mis_valid", 32'(mem_asm.valid), 32'd1);
    chk("mis_fault", 32'(mem_asm.fault), 32'd0);
    chk("mis_result", mem_asm.mem_result, 32'h5566_7788);
`endif
    cyc();

    // Mixed table, checked by the compare process.
    run_mem(SH,  32'h0000_2002, 32'h1234_BEEF, 32'h0,          0, 0);
    run_mem(SH,  32'h0000_2003, 32'h1234_BEEF, 32'h0,          1, 1);
    run_mem(SW,  32'h0000_2000, 32'h1122_3344, 32'h0,          2, 0);
    run_mem(SW,  32'h0000_2001, 32'h1122_3344, 32'h0,          0, 2);
    run_mem(SB,  32'h0000_2001, 32'hFFFF_FF5A, 32'h0,          0, 3);
    run_mem(LBU, 32'h0000_2001, 32'd0,         32'hAABB_CCDD, 1, 0);
    run_mem(LH,  32'h0000_2001, 32'd0,         32'h0102_0304, 0, 1);
    run_mem(LW,  32'h0000_2008, 32'd0,         32'h7777_8888, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of WAIT cycles without dmem_resp_valid before the access is faulted (1..65535).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset rst, synchronous, active-high.
REQ-004 en  in  1  stage enable; low = no new instruction accepted.
REQ-005 next_rdy  in  1  downstream (assembly stage) accepts mem_asm this cycle.
REQ-006 ex_mem  in  core::ex_mem_t  upstream bundle: de_inst, pc, rs1_value, rs2_value, ex_result, ex_addr, valid.
REQ-007 mem_asm  out  core::mem_asm_t  registered bundle: de_inst, pc, rs1_value, rs2_value, ex_result, ex_addr, mem_result, fault, valid.
REQ-008 rdy  out  1  stage accepts ex_mem this cycle.
REQ-009 dmem_req_valid  out  1  data memory request valid.
REQ-010 dmem_req_ready  in  1  memory accepts request.
REQ-011 dmem_addr  out  32  word-aligned address (ex_addr with bits [1:0] cleared).
REQ-012 dmem_we  out  1  1 = store, 0 = load.
REQ-013 dmem_wmask  out  4  store byte enables.
REQ-014 dmem_wdata  out  32  lane-aligned store data.
REQ-015 dmem_resp_valid  in  1  response/ack, one cycle.
REQ-016 dmem_rdata  in  32  raw load word.

Function
REQ-017 States IDLE, REQ, WAIT, DONE; rdy = en && next_rdy && state==IDLE.
REQ-018 IDLE, rdy, ex_mem.valid, opcode not load/store: mem_asm loaded next edge with fields copied, mem_result=0, fault=0, valid=1 (latency 1).
REQ-019 IDLE, rdy, ex_mem.valid, opcode load/store: capture ex_mem internally, go REQ.
REQ-020 REQ: dmem_req_valid=1 with addr/we/wmask/wdata from captured bundle; on dmem_req_ready go WAIT, timeout counter cleared.
REQ-021 Store alignment, off=ex_addr[1:0]: sb wmask=4'b0001<<off, sh 4'b0011<<off, sw 4'b1111; wdata=rs2_value<<(8*off); mask bits shifted beyond bit 3 are dropped; loads drive wmask=0.
REQ-022 WAIT: on dmem_resp_valid latch mem_result=dmem_rdata (loads) or 0 (stores), fault=0, go DONE.
REQ-023 WAIT: counter increments each cycle without response; on reaching TIMEOUT_CYCLES set fault=1, mem_result=0, go DONE; response in that same cycle wins (fault=0).
REQ-024 DONE: when next_rdy, mem_asm loaded with captured bundle, valid=1, go IDLE; otherwise hold DONE.
REQ-025 mem_asm.valid <= 0 on any edge with next_rdy=1 and nothing handed over; next_rdy=0 holds mem_asm unchanged.
REQ-026 Minimum memory latency: accept T, request T+1, response T+2, DONE T+3, mem_asm valid at T+4.
REQ-027 dmem_resp_valid outside WAIT is ignored; dmem_req_valid is 0 outside REQ.
REQ-028 Load data is not shifted or sign-extended here; byte selection is downstream using ex_addr.

Reset
REQ-029 rst: state=IDLE, counter=0, mem_asm=core::mem_asm_rst (valid=0, fault=0), dmem_req_valid=0, captured bundle cleared.
REQ-030 rst in REQ/WAIT/DONE aborts the access without output; a response after reset is ignored per REQ-027.

Configuration
REQ-031 MEM_STAGE_MISALIGN_CHECK_EN defined: lh/lhu/sh with ex_addr[0]=1, or lw/sw with ex_addr[1:0]!=0, skip REQ/WAIT, go DONE with fault=1, mem_result=0, no dmem request.
REQ-032 MEM_STAGE_MISALIGN_CHECK_EN undefined: misaligned accesses are issued per REQ-021 and never faulted by this stage.

Structure
REQ-033 core package holds ex_mem_t, mem_asm_t (including fault), mem_asm_rst, mem_state_t enum; rv32i package holds opcode/funct3 constants.
REQ-034 One combinational sub-module mem_store_align (funct3, ex_addr, rs2_value -> wmask, wdata).

Verification
REQ-035 addi valid, next_rdy=1 -> mem_asm.valid=1 next cycle, mem_result=0, no dmem_req_valid.
REQ-036 lw addr 0x1004, ready=1, resp next cycle rdata 0xDEADBEEF -> dmem_addr 0x1004, mem_result 0xDEADBEEF at T+4, fault=0.
REQ-037 sb addr 0x2003, rs2=0x000000A5 -> wmask 4'b1000, wdata 0xA5000000, we=1.
REQ-038 TIMEOUT_CYCLES=4, lw, no response -> fault=1, mem_result=0 after 4 WAIT cycles; response on 4th cycle -> fault=0.
REQ-039 resp arrives with next_rdy=0 for 3 cycles -> DONE held, rdy=0, mem_asm unchanged; released on next_rdy=1.
REQ-040 rst asserted in WAIT, late resp_valid after -> mem_asm.valid stays 0, state IDLE; macro defined, lw at 0x1002 -> fault=1, no request.
